// File: rtl/gumnut_pkg.sv
// Shared types and constants for the Gumnut ALU multi-cycle datapath blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gumnut_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    // Counter must be able to hold DIV_WIDTH itself, hence the +1.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/seq_divider_subtractor.sv
// Combinational W-bit unsigned subtract a - b, built as a + ~b + 1 like the adder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum;

    // Two's-complement add; a missing carry-out means a < b.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        diff   = sum[W-1:0];
        borrow = ~sum[W];
    end

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Latency: WIDTH+1 cycles start-to-done; 1 cycle for divide-by-zero.
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module seq_divider
    import gumnut_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start,
    input  logic [WIDTH-1:0] IA,
    input  logic [WIDTH-1:0] IB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] IQ,
    output logic [WIDTH-1:0] IR,
    output logic             dzout
);

    // Legacy-style state constants mapped onto the shared enum encoding.
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    // Reuse the shared counter width when at the default size.
    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             trial_borrow;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             accept;
    logic             last_iter;
    logic             div_zero;
    logic             unused_trial_msb;

    // Shift the next dividend bit into the partial remainder and try the subtract.
    always_comb begin
        rem_sh = {rem, q[WIDTH-1]};
    end

    subtractor #(
        .W (WIDTH + 1)
    ) u_sub (
        .a      (rem_sh),
        .b      ({1'b0, dvsr}),
        .diff   (trial),
        .borrow (trial_borrow)
    );

    // Restore on borrow, otherwise take the difference; trial MSB is zero whenever it is used.
    always_comb begin
        rem_nxt          = trial_borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        q_nxt            = {q[WIDTH-2:0], ~trial_borrow};
        unused_trial_msb = trial[WIDTH];
        accept           = start && (state != S_RUN);
        div_zero         = (IB == '0);
        last_iter        = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
        busy             = (state == S_RUN);
        done             = (state == S_DONE);
    end

    // Control FSM plus the internal shift/divisor registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem   <= '0;
            q     <= '0;
            dvsr  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rem <= '0;
                        cnt <= '0;
                        if (div_zero) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                            q     <= IA;
                            dvsr  <= IB;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem <= rem_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result registers: loaded only at the final iteration or on a divide-by-zero accept.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            IQ    <= '0;
            IR    <= '0;
            dzout <= 1'b0;
        end else if (accept) begin
            if (div_zero) begin
                IQ    <= '1;
                IR    <= IA;
                dzout <= 1'b1;
            end else begin
                dzout <= 1'b0;
            end
        end else if (last_iter) begin
            IQ <= q_nxt;
            IR <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_divider;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start;
    logic [7:0] IA;
    logic [7:0] IB;
    logic       busy;
    logic       done;
    logic [7:0] IQ;
    logic [7:0] IR;
    logic       dzout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference view of the held result registers.
    logic [7:0] m_q  = 8'd0;
    logic [7:0] m_r  = 8'd0;
    logic       m_dz = 1'b0;

    seq_divider #(.WIDTH(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (start),
        .IA     (IA),
        .IB     (IB),
        .busy   (busy),
        .done   (done),
        .IQ     (IQ),
        .IR     (IR),
        .dzout  (dzout)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands and start for exactly one sampling edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk_i);
        start = 1'b1;
        IA    = a;
        IB    = b;
        @(posedge clk_i);
        #1;
    endtask

    // Called just after the accept edge; follows the run to its done cycle.
    task automatic wait_done(input logic [7:0] a, input logic [7:0] b, input bit mid_pulse);
        int         lat;
        int         busy_cnt;
        logic [7:0] eq;
        logic [7:0] er;
        logic       edz;
        lat      = 1;
        busy_cnt = 0;
        if (b == 8'd0) begin
            eq  = 8'hFF;
            er  = a;
            edz = 1'b1;
        end else begin
            eq  = a / b;
            er  = a % b;
            edz = 1'b0;
        end
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            check("excl", busy & done, 0);
            check("hold_iq", IQ, m_q);
            check("hold_ir", IR, m_r);
            check("run_dz", dzout, 0);
            if (mid_pulse && lat == 3) begin
                start = 1'b1;
                IA    = 8'd9;
                IB    = 8'd3;
            end else begin
                start = 1'b0;
                IA    = 8'($urandom);
                IB    = 8'($urandom);
            end
            @(posedge clk_i);
            #1;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, (b == 8'd0) ? 1 : 9);
        check("busy_cycles", busy_cnt, (b == 8'd0) ? 0 : 8);
        check("busy_at_done", busy, 0);
        check("iq", IQ, eq);
        check("ir", IR, er);
        check("dz", dzout, edz);
        if (b != 8'd0) begin
            check("ident", 32'(IQ) * 32'(b) + 32'(IR), 32'(a));
            check("rem_lt_div", (IR < b) ? 1 : 0, 1);
        end
        m_q  = eq;
        m_r  = er;
        m_dz = edz;
    endtask

    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input bit mid_pulse);
        launch(a, b);
        wait_done(a, b, mid_pulse);
        @(posedge clk_i);
        #1;
        check("done_drop", done, 0);
        check("hold_after", IQ, m_q);
    endtask

    initial begin
        int ndone;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_ni = 1'b0;
        start  = 1'b0;
        IA     = 8'd0;
        IB     = 8'd0;
        @(posedge clk_i);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_iq", IQ, 0);
        check("rst_ir", IR, 0);
        check("rst_dz", dzout, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed cases.
        do_div(8'd200, 8'd7, 1'b0);
        do_div(8'd255, 8'd1, 1'b0);
        do_div(8'd5, 8'd9, 1'b0);
        do_div(8'd42, 8'd0, 1'b0);
        do_div(8'd13, 8'd4, 1'b0);
        do_div(8'd100, 8'd10, 1'b1);

        // Reset just before iteration 4 aborts the run with no done pulse.
        launch(8'd123, 8'd11);
        start = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_iq", IQ, 0);
        check("mid_rst_ir", IR, 0);
        check("mid_rst_dz", dzout, 0);
        m_q  = 8'd0;
        m_r  = 8'd0;
        m_dz = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        ndone  = 0;
        repeat (12) begin
            @(posedge clk_i);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        do_div(8'd77, 8'd6, 1'b0);

        // Back-to-back: start asserted during the done cycle.
        launch(8'd60, 8'd7);
        wait_done(8'd60, 8'd7, 1'b0);
        start = 1'b1;
        IA    = 8'd17;
        IB    = 8'd5;
        @(posedge clk_i);
        #1;
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        wait_done(8'd17, 8'd5, 1'b0);
        @(posedge clk_i);
        #1;
        check("b2b_done_drop", done, 0);

        // Randomised operand pairs, with a zero divisor mixed in regularly.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 50 == 7) ? 8'd0 : 8'($urandom_range(0, 255));
            do_div(ra, rb, (i % 10 == 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
